// File: rtl/interval_timer.sv
// -----------------------------------------------------------------------------
// interval_timer
//
// Consumer side of the time-parameter lookup interface. On a start request
// from the traffic-light sequencer it fetches the requested interval length
// from the time-parameter block, counts it down in seconds on the 1 Hz
// enable, and pulses expired when the interval runs out. The combined
// base+ext interval (code 2'b11) is built here by fetching base, then ext,
// and adding them.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-low reset
//   start_timer    in   one-cycle start request (restarts if already busy)
//   req_code       in   requested interval: 00 base, 10 yel, 01 ext, 11 base+ext
//   one_hz_enable  in   single-cycle tick, once per second
//   value          in   registered value returned by the time-parameter block
//   interval_code  out  code presented to the time-parameter block
//   busy           out  high from start acceptance until the expired pulse
//   remaining      out  seconds left, for the display
//   expired        out  one-cycle pulse at the end of an interval
//
// CNT_W must be at least VAL_W+1 so that the sum of two maximum values fits.
// -----------------------------------------------------------------------------
module interval_timer #(
  parameter int VAL_W = 4,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_timer,
  input  logic [1:0]       req_code,
  input  logic             one_hz_enable,
  input  logic [VAL_W-1:0] value,
  output logic [1:0]       interval_code,
  output logic             busy,
  output logic [CNT_W-1:0] remaining,
  output logic             expired
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH_A = 3'd1,
    S_WAIT_A  = 3'd2,
    S_FETCH_B = 3'd3,
    S_WAIT_B  = 3'd4,
    S_CHECK   = 3'd5,
    S_COUNT   = 3'd6
  } state_t;

  localparam logic [1:0]       CODE_BASE = 2'b00;
  localparam logic [1:0]       CODE_EXT  = 2'b01;
  localparam logic [1:0]       CODE_SUM  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_nxt_s;
  logic [1:0]       code_r;
  logic [1:0]       code_nxt_s;
  logic [CNT_W-1:0] sum_r;
  logic [CNT_W-1:0] sum_nxt_s;
  logic [1:0]       ic_nxt_s;
  logic             busy_nxt_s;
  logic [CNT_W-1:0] rem_nxt_s;
  logic             exp_nxt_s;
  logic [CNT_W-1:0] value_ext_s;

  assign value_ext_s = {{(CNT_W-VAL_W){1'b0}}, value};

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_nxt_s = state_r;
    code_nxt_s  = code_r;
    sum_nxt_s   = sum_r;
    ic_nxt_s    = interval_code;
    busy_nxt_s  = busy;
    rem_nxt_s   = remaining;
    exp_nxt_s   = 1'b0;

    if (start_timer) begin
      // A start in any state (including the final-tick cycle) restarts the
      // fetch; the aborted interval never produces an expired pulse.
      code_nxt_s  = req_code;
      busy_nxt_s  = 1'b1;
      ic_nxt_s    = (req_code == CODE_SUM) ? CODE_BASE : req_code;
      state_nxt_s = S_FETCH_A;
    end else begin
      case (state_r)
        S_IDLE: begin
          state_nxt_s = S_IDLE;
        end
        S_FETCH_A: begin
          state_nxt_s = S_WAIT_A;
        end
        S_WAIT_A: begin
          sum_nxt_s = value_ext_s;
          if (code_r == CODE_SUM) begin
            ic_nxt_s    = CODE_EXT;
            state_nxt_s = S_FETCH_B;
          end else begin
            rem_nxt_s   = value_ext_s;
            state_nxt_s = S_CHECK;
          end
        end
        S_FETCH_B: begin
          state_nxt_s = S_WAIT_B;
        end
        S_WAIT_B: begin
          rem_nxt_s   = sum_r + value_ext_s;
          state_nxt_s = S_CHECK;
        end
        S_CHECK: begin
          if (remaining == CNT_ZERO) begin
            // Zero-length interval expires without waiting for a tick.
            exp_nxt_s   = 1'b1;
            busy_nxt_s  = 1'b0;
            state_nxt_s = S_IDLE;
          end else begin
            state_nxt_s = S_COUNT;
          end
        end
        S_COUNT: begin
          if (one_hz_enable) begin
            if (remaining <= CNT_ONE) begin
              // Last second: clamp at zero rather than wrapping.
              rem_nxt_s   = CNT_ZERO;
              exp_nxt_s   = 1'b1;
              busy_nxt_s  = 1'b0;
              state_nxt_s = S_IDLE;
            end else begin
              rem_nxt_s = remaining - CNT_ONE;
            end
          end else begin
            state_nxt_s = S_COUNT;
          end
        end
        default: begin
          busy_nxt_s  = 1'b0;
          state_nxt_s = S_IDLE;
        end
      endcase
    end
  end

  // State, latched code, sum and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= S_IDLE;
      code_r        <= 2'b00;
      sum_r         <= CNT_ZERO;
      interval_code <= 2'b00;
      busy          <= 1'b0;
      remaining     <= CNT_ZERO;
      expired       <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      code_r        <= code_nxt_s;
      sum_r         <= sum_nxt_s;
      interval_code <= ic_nxt_s;
      busy          <= busy_nxt_s;
      remaining     <= rem_nxt_s;
      expired       <= exp_nxt_s;
    end
  end

  interval_timer_checker #(
    .CNT_W(CNT_W)
  ) u_checker (
    .clk       (clk),
    .reset     (reset),
    .in_count  (state_r == S_COUNT),
    .busy      (busy),
    .expired   (expired),
    .remaining (remaining)
  );

endmodule

// -----------------------------------------------------------------------------
// interval_timer_checker
//
// Invariants of interval_timer: the expired pulse is never seen together with
// busy, and the counting state never holds a zero count.
//
// Ports:
//   clk, reset  clock and active-low reset of the timer
//   in_count    timer is in its counting state
//   busy, expired, remaining  timer outputs
// -----------------------------------------------------------------------------
module interval_timer_checker #(
  parameter int CNT_W = 5
) (
  input logic             clk,
  input logic             reset,
  input logic             in_count,
  input logic             busy,
  input logic             expired,
  input logic [CNT_W-1:0] remaining
);

  a_expired_not_busy : assert property (
    @(posedge clk) disable iff (!reset) expired |-> !busy
  );

  a_count_nonzero : assert property (
    @(posedge clk) disable iff (!reset) in_count |-> (remaining != {CNT_W{1'b0}})
  );

endmodule

// File: tb/tb_interval_timer.sv
// -----------------------------------------------------------------------------
// tb_interval_timer
//
// Bench for interval_timer: a behavioural time-parameter block, a fixed
// vector table, directed multi-cycle sequences and a randomized run checked
// against a latency/arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_interval_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_timer;
  logic [1:0] req_code;
  logic       one_hz_enable;
  logic [3:0] value = 4'd0;
  logic [1:0] interval_code;
  logic       busy;
  logic [4:0] remaining;
  logic       expired;

  interval_timer #(.VAL_W(4), .CNT_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .start_timer   (start_timer),
    .req_code      (req_code),
    .one_hz_enable (one_hz_enable),
    .value         (value),
    .interval_code (interval_code),
    .busy          (busy),
    .remaining     (remaining),
    .expired       (expired)
  );

  always #5 clk = ~clk;

  // Time-parameter block: registers the looked-up value on each clk edge.
  logic [3:0] tbl_base, tbl_yel, tbl_ext;
  always @(posedge clk) begin
    case (interval_code)
      2'b00:   value <= tbl_base;
      2'b10:   value <= tbl_yel;
      2'b01:   value <= tbl_ext;
      default: value <= 4'd0;
    endcase
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // After a start the interval length is known from the table; it appears
  // on remaining after the fetch latency (2 edges single, 4 edges for the
  // sum), is checked one edge later, then counts down on ticks.
  bit         m_busy, m_exp, m_counting, m_dbl;
  int         m_rem, m_age, m_val;
  logic [1:0] m_ic;

  function automatic int interval_of(input logic [1:0] code);
    case (code)
      2'b00:   return int'(tbl_base);
      2'b10:   return int'(tbl_yel);
      2'b01:   return int'(tbl_ext);
      default: return int'(tbl_base) + int'(tbl_ext);
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 0; m_exp = 0; m_counting = 0; m_dbl = 0;
    m_rem = 0; m_age = 0; m_val = 0; m_ic = 2'b00;
  endtask

  task automatic model_update(input bit st, input logic [1:0] code, input bit tick);
    int load_age;
    m_exp = 0;
    if (st) begin
      m_busy = 1; m_counting = 0; m_dbl = (code == 2'b11);
      m_ic = m_dbl ? 2'b00 : code;
      m_val = interval_of(code);
      m_age = 1;
    end else if (m_busy && !m_counting) begin
      load_age = m_dbl ? 4 : 2;
      if (m_dbl && m_age == 2) m_ic = 2'b01;
      if (m_age == load_age) m_rem = m_val;
      if (m_age == load_age + 1) begin
        if (m_rem == 0) begin m_exp = 1; m_busy = 0; end
        else m_counting = 1;
      end
      m_age++;
    end else if (m_counting && tick) begin
      m_rem--;
      if (m_rem == 0) begin m_exp = 1; m_busy = 0; m_counting = 0; end
    end
  endtask

  task automatic step(input bit st, input logic [1:0] code, input bit tick);
    start_timer = st; req_code = code; one_hz_enable = tick;
    @(posedge clk);
    model_update(st, code, tick);
    #1;
    start_timer = 1'b0; one_hz_enable = 1'b0;
  endtask

  task automatic compare_model();
    check("busy",          int'(busy),          int'(m_busy));
    check("expired",       int'(expired),       int'(m_exp));
    check("remaining",     int'(remaining),     m_rem);
    check("interval_code", int'(interval_code), int'(m_ic));
  endtask

  task automatic step_chk(input bit st, input logic [1:0] code, input bit tick);
    step(st, code, tick);
    compare_model();
  endtask

  // Fetch to first COUNT cycle after a start already applied.
  task automatic settle(input int n);
    for (int k = 0; k < n; k++) step_chk(1'b0, 2'b00, 1'b0);
  endtask

  typedef struct {
    bit         st;
    logic [1:0] code;
    bit         tick;
    bit         e_busy;
    bit         e_exp;
    logic [4:0] e_rem;
    logic [1:0] e_ic;
  } vec_t;

  vec_t vt [12];

  initial begin
    reset = 1'b0; start_timer = 1'b0; req_code = 2'b00; one_hz_enable = 1'b0;
    tbl_base = 4'd6; tbl_yel = 4'd4; tbl_ext = 4'd3;
    model_reset();

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("rst_busy", int'(busy), 0);
    check("rst_expired", int'(expired), 0);
    check("rst_remaining", int'(remaining), 0);
    check("rst_interval_code", int'(interval_code), 0);
    reset = 1'b1;

    // Table: yel=0 zero-length interval, then a 2-second ext interval
    tbl_yel = 4'd0; tbl_ext = 4'd2;
    vt[0]  = '{1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 5'd0, 2'b10};
    vt[1]  = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 5'd0, 2'b10};
    vt[2]  = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 5'd0, 2'b10};
    vt[3]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 5'd0, 2'b10};
    vt[4]  = '{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 5'd0, 2'b01};
    vt[5]  = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 5'd0, 2'b01};
    vt[6]  = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 5'd2, 2'b01};
    vt[7]  = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 5'd2, 2'b01};
    vt[8]  = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 5'd1, 2'b01};
    vt[9]  = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 5'd1, 2'b01};
    vt[10] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 5'd0, 2'b01};
    vt[11] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 2'b01};
    for (int i = 0; i < 12; i++) begin
      step(vt[i].st, vt[i].code, vt[i].tick);
      check("tbl_busy",          int'(busy),          int'(vt[i].e_busy));
      check("tbl_expired",       int'(expired),       int'(vt[i].e_exp));
      check("tbl_remaining",     int'(remaining),     int'(vt[i].e_rem));
      check("tbl_interval_code", int'(interval_code), int'(vt[i].e_ic));
    end
    tbl_yel = 4'd4; tbl_ext = 4'd3;

    // Base interval of 6 seconds
    step_chk(1'b1, 2'b00, 1'b0);
    check("base_code", int'(interval_code), 0);
    settle(2);
    check("base_load", int'(remaining), 6);
    settle(1);
    for (int i = 0; i < 6; i++) begin
      step_chk(1'b0, 2'b00, 1'b1);
      check("base_expired", int'(expired), (i == 5) ? 1 : 0);
    end
    step_chk(1'b0, 2'b00, 1'b0);

    // Base+ext: 6+3
    step_chk(1'b1, 2'b11, 1'b0);
    check("sum_code_a", int'(interval_code), 0);
    step_chk(1'b0, 2'b00, 1'b0);
    check("sum_code_a2", int'(interval_code), 0);
    step_chk(1'b0, 2'b00, 1'b0);
    check("sum_code_b", int'(interval_code), 1);
    settle(2);
    check("sum_load", int'(remaining), 9);
    settle(1);
    for (int i = 0; i < 9; i++) begin
      step_chk(1'b0, 2'b00, 1'b1);
      check("sum_expired", int'(expired), (i == 8) ? 1 : 0);
    end

    // Maximum sum 15+15 = 30
    tbl_base = 4'd15; tbl_ext = 4'd15;
    step_chk(1'b1, 2'b11, 1'b0);
    settle(4);
    check("max_load", int'(remaining), 30);
    settle(1);
    for (int i = 0; i < 30; i++) begin
      step_chk(1'b0, 2'b00, 1'b1);
      check("max_expired", int'(expired), (i == 29) ? 1 : 0);
    end
    tbl_base = 4'd6; tbl_ext = 4'd3;

    // Abort at remaining=3 by an ext request
    step_chk(1'b1, 2'b00, 1'b0);
    settle(3);
    for (int i = 0; i < 3; i++) step_chk(1'b0, 2'b00, 1'b1);
    check("abort_pre", int'(remaining), 3);
    step_chk(1'b1, 2'b01, 1'b0);
    check("abort_noexp", int'(expired), 0);
    settle(2);
    check("abort_reload", int'(remaining), 3);
    settle(1);
    for (int i = 0; i < 3; i++) step_chk(1'b0, 2'b00, 1'b1);
    check("abort_expired", int'(expired), 1);

    // Start in the cycle of the final tick: restart wins
    step_chk(1'b1, 2'b01, 1'b0);
    settle(3);
    step_chk(1'b0, 2'b00, 1'b1);
    step_chk(1'b0, 2'b00, 1'b1);
    step_chk(1'b1, 2'b00, 1'b1);
    check("race_noexp", int'(expired), 0);
    check("race_busy", int'(busy), 1);
    settle(3);
    for (int i = 0; i < 6; i++) step_chk(1'b0, 2'b00, 1'b1);
    check("race_expired", int'(expired), 1);
    // Start while expired is high
    step_chk(1'b1, 2'b10, 1'b0);
    check("exp_start_busy", int'(busy), 1);
    settle(3);
    for (int i = 0; i < 4; i++) step_chk(1'b0, 2'b00, 1'b1);
    check("yel_expired", int'(expired), 1);

    // Asynchronous reset mid-count
    step_chk(1'b1, 2'b00, 1'b0);
    settle(3);
    step_chk(1'b0, 2'b00, 1'b1);
    step_chk(1'b0, 2'b00, 1'b1);
    #3 reset = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_expired", int'(expired), 0);
    check("arst_remaining", int'(remaining), 0);
    check("arst_interval_code", int'(interval_code), 0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) step_chk(1'b0, 2'b00, 1'b1);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      bit         st, tk;
      logic [1:0] cd;
      st = ($urandom_range(0, 59) == 0);
      cd = 2'($urandom_range(0, 3));
      tk = ($urandom_range(0, 2) == 0);
      if (!m_busy && !st && $urandom_range(0, 19) == 0) begin
        tbl_base = 4'($urandom_range(0, 15));
        tbl_yel  = 4'($urandom_range(0, 15));
        tbl_ext  = 4'($urandom_range(0, 15));
      end
      step_chk(st, cd, tk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
